// File: rtl/streebog_g_ctrl.sv
// Sequencer for the Streebog compression function g_N(h,m): runs the 12-round E
// cipher and its key schedule by time-sharing one external LPSX stage.
module streebog_g_ctrl #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] h_i,
  input  logic [DATA_WIDTH-1:0] m_i,
  input  logic [DATA_WIDTH-1:0] n_i,
  output logic                  ready_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] g_o,
  output logic                  lpsx_valid_o,
  output logic [DATA_WIDTH-1:0] lpsx_a_o,
  output logic [DATA_WIDTH-1:0] lpsx_b_o,
  input  logic                  lpsx_valid_i,
  input  logic [DATA_WIDTH-1:0] lpsx_data_i,
  output logic [3:0]            const_idx_o,
  input  logic [DATA_WIDTH-1:0] const_i
);

  typedef enum logic [2:0] {
    IDLE, K0_ISS, K0_WT, D_ISS, D_WT, K_ISS, K_WT, FIN
  } state_e;

  state_e                state_q;
  logic [3:0]            round_q;
  logic [DATA_WIDTH-1:0] k_q, x_q, h_q, m_q, n_q, g_q;
  logic                  valid_q, done_q;
  logic [DATA_WIDTH-1:0] g_d;

  assign g_d = k_q ^ x_q ^ h_q ^ m_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      round_q <= 4'd0;
      k_q     <= '0;
      x_q     <= '0;
      h_q     <= '0;
      m_q     <= '0;
      n_q     <= '0;
      g_q     <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            h_q     <= h_i;
            m_q     <= m_i;
            n_q     <= n_i;
            x_q     <= m_i;
            round_q <= 4'd0;
            valid_q <= 1'b1;
            state_q <= K0_ISS;
          end
        end
        K0_ISS: state_q <= K0_WT;
        K0_WT: begin
          if (lpsx_valid_i) begin
            k_q     <= lpsx_data_i;
            round_q <= 4'd1;
            valid_q <= 1'b1;
            state_q <= D_ISS;
          end
        end
        D_ISS: state_q <= D_WT;
        D_WT: begin
          if (lpsx_valid_i) begin
            x_q     <= lpsx_data_i;
            valid_q <= 1'b1;
            state_q <= K_ISS;
          end
        end
        K_ISS: state_q <= K_WT;
        K_WT: begin
          if (lpsx_valid_i) begin
            k_q <= lpsx_data_i;
            // The key produced in round 12 is K13, the final whitening key
            if (round_q < 4'd12) begin
              round_q <= round_q + 4'd1;
              valid_q <= 1'b1;
              state_q <= D_ISS;
            end else begin
              round_q <= 4'd0;
              state_q <= FIN;
            end
          end
        end
        FIN: begin
          g_q     <= g_d;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    lpsx_a_o = '0;
    lpsx_b_o = '0;
    case (state_q)
      K0_ISS: begin
        lpsx_a_o = h_q;
        lpsx_b_o = n_q;
      end
      D_ISS: begin
        lpsx_a_o = k_q;
        lpsx_b_o = x_q;
      end
      K_ISS: begin
        lpsx_a_o = k_q;
        lpsx_b_o = const_i;
      end
      default: begin
        lpsx_a_o = '0;
        lpsx_b_o = '0;
      end
    endcase
  end

  assign const_idx_o  = (round_q == 4'd0) ? 4'd0 : round_q - 4'd1;
  assign ready_o      = (state_q == IDLE);
  assign done_o       = done_q;
  assign g_o          = g_q;
  assign lpsx_valid_o = valid_q;

endmodule

// File: tb/tb_streebog_g_ctrl.sv
// Randomized bench for streebog_g_ctrl: a 3-cycle LPSX stub and a const ROM
// around the DUT, with g_N recomputed directly from its defining equations.
module tb_streebog_g_ctrl;
  localparam int DW = 512;
  localparam int L  = 3;

  logic          clk;
  logic          rstn_i;
  logic          start_i;
  logic [DW-1:0] h_i, m_i, n_i;
  logic          ready_o, done_o;
  logic [DW-1:0] g_o;
  logic          lpsx_valid_o;
  logic [DW-1:0] lpsx_a_o, lpsx_b_o;
  logic          lpsx_valid_i;
  logic [DW-1:0] lpsx_data_i;
  logic [3:0]    const_idx_o;
  logic [DW-1:0] const_i;

  logic [DW-1:0] cmem [16];
  int            stub_mode;
  logic          spur;
  logic [DW-1:0] spur_dat;
  logic [L-1:0]  pv = '0;
  logic [DW-1:0] pd [L];

  int n_cmp = 0;
  int n_bad = 0;
  int npulse = 0;
  int ndone = 0;
  int opnd_bad = 0;
  int idx_steps = 0;
  int idx_bad = 0;
  logic [3:0] idx_prev = 4'd0;

  streebog_g_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk_i(clk), .rstn_i(rstn_i), .start_i(start_i),
    .h_i(h_i), .m_i(m_i), .n_i(n_i),
    .ready_o(ready_o), .done_o(done_o), .g_o(g_o),
    .lpsx_valid_o(lpsx_valid_o), .lpsx_a_o(lpsx_a_o), .lpsx_b_o(lpsx_b_o),
    .lpsx_valid_i(lpsx_valid_i), .lpsx_data_i(lpsx_data_i),
    .const_idx_o(const_idx_o), .const_i(const_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign const_i      = cmem[const_idx_o];
  assign lpsx_valid_i = pv[L-1] | spur;
  assign lpsx_data_i  = spur ? spur_dat : pd[L-1];

  // Mode 0 is plain XOR; mode 1 is asymmetric so swapped operands show up
  function automatic logic [DW-1:0] lpsx_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] t;
    t = a ^ b;
    if (stub_mode == 0) return t;
    return {t[DW-6:0], t[DW-1:DW-5]} + a;
  endfunction

  function automatic logic [DW-1:0] g_ref(input logic [DW-1:0] h, input logic [DW-1:0] m,
                                          input logic [DW-1:0] n);
    logic [DW-1:0] k, x;
    k = lpsx_f(h, n);
    x = m;
    for (int i = 1; i <= 12; i++) begin
      x = lpsx_f(k, x);
      k = lpsx_f(k, cmem[i-1]);
    end
    return k ^ x ^ h ^ m;
  endfunction

  function automatic logic [DW-1:0] rnd512();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < DW/32; i++) r = {r[DW-33:0], $urandom()};
    return r;
  endfunction

  always @(posedge clk) begin
    pv    <= {pv[L-2:0], lpsx_valid_o};
    pd[0] <= lpsx_f(lpsx_a_o, lpsx_b_o);
    for (int i = 1; i < L; i++) pd[i] <= pd[i-1];
  end

  always @(posedge clk) begin
    if (lpsx_valid_o) npulse++;
    if (done_o) ndone++;
  end

  always @(negedge clk) begin
    if (!lpsx_valid_o && (lpsx_a_o != '0 || lpsx_b_o != '0)) opnd_bad++;
    if (const_idx_o != idx_prev) begin
      idx_steps++;
      if (const_idx_o != idx_prev + 4'd1 && const_idx_o != 4'd0) idx_bad++;
    end
    if (const_idx_o > 4'd11) idx_bad++;
    idx_prev = const_idx_o;
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [DW-1:0] h, input logic [DW-1:0] m,
                         input logic [DW-1:0] n, input bit hold, input int spur_at);
    int lat, p0, d0, s0;
    logic [DW-1:0] exp;
    exp = g_ref(h, m, n);
    @(negedge clk);
    h_i = h; m_i = m; n_i = n; start_i = 1'b1;
    s0 = idx_steps;
    @(posedge clk);
    p0 = npulse;
    d0 = ndone;
    @(negedge clk);
    if (!hold) start_i = 1'b0;
    h_i = rnd512(); m_i = rnd512(); n_i = rnd512();
    lat = 1;
    while (!done_o && lat < 1000) begin
      if (spur_at > 0 && lpsx_valid_o && (npulse - p0 + 1) == spur_at) begin
        spur = 1'b1;
        spur_dat = rnd512();
      end
      @(negedge clk);
      spur = 1'b0;
      lat++;
    end
    start_i = 1'b0;
    check("latency", lat, 25*L + 27);
    check("done", done_o, 1);
    check("ready_at_done", ready_o, 1);
    check("g", g_o, exp);
    check("lpsx_pulses", npulse - p0, 25);
    check("idx_steps", idx_steps - s0, 12);
    @(negedge clk);
    check("done_width", done_o, 0);
    check("one_done", ndone - d0, 1);
    check("ready_idle", ready_o, 1);
    check("g_hold", g_o, exp);
  endtask

  initial begin
    int w, p0, d0;
    rstn_i = 1'b0; start_i = 1'b0; spur = 1'b0; spur_dat = '0;
    h_i = '0; m_i = '0; n_i = '0; stub_mode = 0;
    for (int i = 0; i < 16; i++) cmem[i] = (i < 12) ? '0 : rnd512();
    repeat (3) @(negedge clk);
    check("rst_ready", ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_valid", lpsx_valid_o, 0);
    check("rst_idx", const_idx_o, 0);
    check("rst_g", g_o, 0);
    rstn_i = 1'b1;

    // Spurious LPSX response while idle
    @(negedge clk);
    spur = 1'b1; spur_dat = rnd512();
    @(negedge clk);
    spur = 1'b0;
    check("idle_spur_ready", ready_o, 1);
    check("idle_spur_valid", lpsx_valid_o, 0);

    run_job({64{8'hA5}}, {64{8'h3C}}, 512'h200, 1'b0, 0);
    check("g_xor_stub", g_o, 512'h200);

    for (int i = 0; i < 12; i++) cmem[i] = DW'(i + 1);
    run_job(rnd512(), rnd512(), rnd512(), 1'b0, 0);

    stub_mode = 1;
    for (int i = 0; i < 12; i++) cmem[i] = rnd512();
    run_job(rnd512(), rnd512(), rnd512(), 1'b0, 0);
    run_job(rnd512(), rnd512(), rnd512(), 1'b1, 0);
    repeat (3) @(negedge clk);
    check("hold_no_restart", ready_o, 1);
    run_job(rnd512(), rnd512(), rnd512(), 1'b0, 6);

    // Reset in round 6 with a response still in flight
    @(negedge clk);
    h_i = rnd512(); m_i = rnd512(); n_i = rnd512(); start_i = 1'b1;
    @(posedge clk);
    p0 = npulse;
    d0 = ndone;
    @(negedge clk);
    start_i = 1'b0;
    w = 0;
    while ((npulse - p0) < 12 && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("reach_round6", idx_prev, 5);
    rstn_i = 1'b0;
    #1;
    check("midrst_ready", ready_o, 1);
    check("midrst_done", done_o, 0);
    check("midrst_valid", lpsx_valid_o, 0);
    check("midrst_idx", const_idx_o, 0);
    check("midrst_g", g_o, 0);
    check("midrst_a", lpsx_a_o, 0);
    @(negedge clk);
    rstn_i = 1'b1;
    repeat (4) @(negedge clk);
    spur = 1'b1; spur_dat = rnd512();
    @(negedge clk);
    spur = 1'b0;
    repeat (8) @(negedge clk);
    check("late_no_done", ndone - d0, 0);
    check("late_ready", ready_o, 1);
    check("late_g", g_o, 0);
    run_job(rnd512(), rnd512(), rnd512(), 1'b0, 2);

    check("operands_zero_outside_iss", opnd_bad, 0);
    check("idx_sequence", idx_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
